// File: rtl/fp_round_pack_if.sv
// Handshake bundle between the multiplier datapath and the round/pack stage.
// Upstream drives the operand side; the round/pack stage drives the result side.
interface fp_round_pack_if #(
  parameter int EW = 8,
  parameter int FW = 23
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 sign_in;
  logic [EW+1:0]        exp_in;
  logic [2*(FW+1)-1:0]  mant_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [EW+FW:0]       result;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output in_valid, sign_in, exp_in, mant_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, sign_in, exp_in, mant_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp_round_pack.sv
// Iterative normalize, round and pack of a significand product into binary32.
// Define FPROUND_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_round_pack #(
  parameter int EW   = 8,
  parameter int FW   = 23,
  parameter int BIAS = 127
) (
  input logic          clock,
  input logic          reset,
  fp_round_pack_if.slave bus
);

  localparam int PW  = 2 * (FW + 1);
  localparam int EXW = EW + 3;
  localparam int RW  = 1 + EW + FW;

  localparam logic signed [EXW-1:0] E_ZERO = '0;
  localparam logic signed [EXW-1:0] E_ONE  = EXW'(1);
  localparam logic signed [EXW-1:0] E_INF  = EXW'(2 * BIAS + 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [PW-1:0]          m_reg, m_next;
  logic signed [EXW-1:0]  e_reg, e_next;
  logic                   s_reg, s_next;
  logic                   z_reg, z_next;
  logic [RW-1:0]          result_reg, result_next;
  logic                   ovf_reg, ovf_next;
  logic                   udf_reg, udf_next;
  logic                   valid_reg, valid_next;

  logic [FW-1:0]          frac_rnd;
  logic signed [EXW-1:0]  e_rnd;
  logic [RW-1:0]          pack_res;
  logic                   pack_ovf;
  logic                   pack_udf;

`ifdef FPROUND_RNE_EN
  logic          lsb, guard, sticky, inc;
  logic [FW+1:0] sig_sum;

  always_comb begin
    lsb     = m_reg[FW];
    guard   = m_reg[FW-1];
    sticky  = |m_reg[FW-2:0];
    inc     = guard & (sticky | lsb);
    sig_sum = {1'b0, m_reg[PW-2 -: FW+1]} + {{(FW+1){1'b0}}, inc};
    // A carry out of the hidden bit leaves 1.000..0, so shifting right keeps the fraction exact.
    if (sig_sum[FW+1]) begin
      frac_rnd = sig_sum[FW:1];
      e_rnd    = e_reg + E_ONE;
    end else begin
      frac_rnd = sig_sum[FW-1:0];
      e_rnd    = e_reg;
    end
  end
`else
  always_comb begin
    frac_rnd = m_reg[PW-3 -: FW];
    e_rnd    = e_reg;
  end
`endif

  always_comb begin
    pack_res = {s_reg, e_rnd[EW-1:0], frac_rnd};
    pack_ovf = 1'b0;
    pack_udf = 1'b0;
    if (z_reg) begin
      pack_res = {s_reg, {(RW-1){1'b0}}};
    end else if (e_rnd <= E_ZERO) begin
      pack_res = {s_reg, {(RW-1){1'b0}}};
      pack_udf = 1'b1;
    end else if (e_rnd >= E_INF) begin
      pack_res = {s_reg, {EW{1'b1}}, {FW{1'b0}}};
      pack_ovf = 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    m_next      = m_reg;
    e_next      = e_reg;
    s_next      = s_reg;
    z_next      = z_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    udf_next    = udf_reg;
    valid_next  = valid_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          s_next     = bus.sign_in;
          e_next     = {bus.exp_in[EW+1], bus.exp_in};
          m_next     = bus.mant_in;
          z_next     = (bus.mant_in == '0);
          state_next = NORM;
        end
      end
      NORM: begin
        if (z_reg) begin
          state_next = ROUND;
        end else if (m_reg[PW-1]) begin
          m_next     = m_reg >> 1;
          e_next     = e_reg + E_ONE;
          state_next = ROUND;
        end else if (m_reg[PW-2]) begin
          state_next = ROUND;
        end else if (e_reg <= E_ZERO) begin
          // Exponent exhausted: stop shifting, the packer flushes this to zero.
          state_next = ROUND;
        end else begin
          m_next = {m_reg[PW-2:0], 1'b0};
          e_next = e_reg - E_ONE;
        end
      end
      ROUND: begin
        result_next = pack_res;
        ovf_next    = pack_ovf;
        udf_next    = pack_udf;
        valid_next  = 1'b1;
        state_next  = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      m_reg      <= '0;
      e_reg      <= '0;
      s_reg      <= 1'b0;
      z_reg      <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      m_reg      <= m_next;
      e_reg      <= e_next;
      s_reg      <= s_next;
      z_reg      <= z_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      udf_reg    <= udf_next;
      valid_reg  <= valid_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = valid_reg;
  assign bus.result    = result_reg;
  assign bus.overflow  = ovf_reg;
  assign bus.underflow = udf_reg;

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed vector table, handshake/reset sequences and
// randomized operands against an arithmetic reference model.
module tb_fp_round_pack;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fp_round_pack_if #(.EW(8), .FW(23)) bus ();

  fp_round_pack #(.EW(8), .FW(23), .BIAS(127)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        s;
    logic [9:0]  ex;
    logic [47:0] mt;
    logic [31:0] res;
    logic        ov;
    logic        un;
    int          lat;
  } vec_t;

  vec_t vt [0:14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, shift as far as the exponent allows,
  // then round by comparing the discarded remainder against one half.
  function automatic void ref_model(input logic s, input logic [9:0] ex, input logic [47:0] mt,
                                    output logic [31:0] r, output logic ov, output logic un,
                                    output int lat);
    int          e;
    int          p;
    int          k;
    longint      m;
    longint      sig;
    longint      rem;
    e   = int'($signed(ex));
    m   = longint'(mt);
    ov  = 1'b0;
    un  = 1'b0;
    k   = 0;
    lat = 2;
    if (mt == 48'h0) begin
      r = {s, 31'h0};
      return;
    end
    p = 0;
    for (int i = 0; i < 48; i++) if (mt[i]) p = i;
    if (p == 47) begin
      m = m / 2;
      e = e + 1;
    end else begin
      k = 46 - p;
      if (e <= 0) k = 0;
      else if (e < k) k = e;
      m = m * (longint'(1) << k);
      e = e - k;
    end
    lat = 2 + k;
    sig = m / (longint'(1) << 23);
    rem = m % (longint'(1) << 23);
`ifdef FPROUND_RNE_EN
    if (rem > 64'h400000 || (rem == 64'h400000 && (sig % 2) == 1)) sig = sig + 1;
    if (sig >= (longint'(1) << 24)) begin
      sig = sig / 2;
      e   = e + 1;
    end
`endif
    if (e <= 0) begin
      r  = {s, 31'h0};
      un = 1'b1;
    end else if (e >= 255) begin
      r  = {s, 8'hFF, 23'h0};
      ov = 1'b1;
    end else begin
      r = {s, 8'(e), 23'(sig)};
    end
  endfunction

  // One complete transaction: capture, wait bounded for result, optional back-pressure, consume.
  task automatic do_op(input string name, input logic s, input logic [9:0] ex, input logic [47:0] mt,
                       input logic [31:0] res, input logic ov, input logic un, input int lat_req,
                       input int hold);
    int lat;
    @(negedge clock);
    check({name, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.sign_in  = s;
    bus.exp_in   = ex;
    bus.mant_in  = mt;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clock);
      lat++;
      #1;
    end
    check({name, ".latency"}, 64'(lat), 64'(lat_req));
    check({name, ".result"}, 64'(bus.result), 64'(res));
    check({name, ".overflow"}, 64'(bus.overflow), 64'(ov));
    check({name, ".underflow"}, 64'(bus.underflow), 64'(un));
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      check({name, ".hold_result"}, 64'(bus.result), 64'(res));
      check({name, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
    check({name, ".consumed"}, 64'(bus.out_valid), 64'd0);
    $display("op %s s=%0b e=%0d m=%h -> res=%h ov=%0b un=%0b lat=%0d", name, s,
             $signed(ex), mt, res, ov, un, lat);
  endtask

  initial begin
    logic [31:0] r_b;
    logic        ov_b, un_b;
    int          lat_b;
    int          lat;
    int          stale;

    vt[0]  = '{1'b0, 10'd127,  48'h9000_0000_0000, 32'h40100000, 1'b0, 1'b0, 2};
`ifdef FPROUND_RNE_EN
    vt[1]  = '{1'b0, 10'd127,  48'h4000_00C0_0000, 32'h3F800002, 1'b0, 1'b0, 2};
    vt[3]  = '{1'b0, 10'd127,  48'h7FFF_FFFF_FFFF, 32'h40000000, 1'b0, 1'b0, 2};
    vt[9]  = '{1'b0, 10'd0,    48'h7FFF_FFFF_FFFF, 32'h00800000, 1'b0, 1'b0, 2};
    vt[11] = '{1'b0, 10'd254,  48'h7FFF_FFFF_FFFF, 32'h7F800000, 1'b1, 1'b0, 2};
`else
    vt[1]  = '{1'b0, 10'd127,  48'h4000_00C0_0000, 32'h3F800001, 1'b0, 1'b0, 2};
    vt[3]  = '{1'b0, 10'd127,  48'h7FFF_FFFF_FFFF, 32'h3FFFFFFF, 1'b0, 1'b0, 2};
    vt[9]  = '{1'b0, 10'd0,    48'h7FFF_FFFF_FFFF, 32'h00000000, 1'b0, 1'b1, 2};
    vt[11] = '{1'b0, 10'd254,  48'h7FFF_FFFF_FFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 2};
`endif
    vt[2]  = '{1'b0, 10'd127,  48'h4000_0040_0000, 32'h3F800000, 1'b0, 1'b0, 2};
    vt[4]  = '{1'b1, 10'd254,  48'h9000_0000_0000, 32'hFF800000, 1'b1, 1'b0, 2};
    vt[5]  = '{1'b0, 10'd200,  48'h0000_0000_0001, 32'h4D000000, 1'b0, 1'b0, 48};
    vt[6]  = '{1'b1, 10'd10,   48'h0000_0000_0001, 32'h80000000, 1'b0, 1'b1, 12};
    vt[7]  = '{1'b1, 10'd50,   48'h0000_0000_0000, 32'h80000000, 1'b0, 1'b0, 2};
    vt[8]  = '{1'b0, 10'h3FB,  48'h4000_0000_0000, 32'h00000000, 1'b0, 1'b1, 2};
    vt[10] = '{1'b0, 10'd254,  48'h4000_0000_0000, 32'h7F000000, 1'b0, 1'b0, 2};
    vt[12] = '{1'b0, 10'h17D,  48'h9000_0000_0000, 32'h7F800000, 1'b1, 1'b0, 2};
    vt[13] = '{1'b0, 10'h381,  48'h8000_0000_0000, 32'h00000000, 1'b0, 1'b1, 2};
    vt[14] = '{1'b0, 10'd1,    48'h1000_0000_0000, 32'h00000000, 1'b0, 1'b1, 3};

    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = '0;
    bus.mant_in   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.result", 64'(bus.result), 64'd0);
    check("rst.flags", 64'({bus.overflow, bus.underflow}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++)
      do_op($sformatf("vec%0d", i), vt[i].s, vt[i].ex, vt[i].mt, vt[i].res, vt[i].ov, vt[i].un,
            vt[i].lat, (i == 0) ? 5 : (i % 3));

    // Next operand offered while the current result is being consumed: it waits for IDLE.
    ref_model(1'b0, 10'd130, 48'h6000_0000_0000, r_b, ov_b, un_b, lat_b);
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.sign_in  = 1'b0;
    bus.exp_in   = 10'd127;
    bus.mant_in  = 48'h9000_0000_0000;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clock);
      lat++;
      #1;
    end
    check("ovl.first_result", 64'(bus.result), 64'h40100000);
    bus.in_valid  = 1'b1;
    bus.exp_in    = 10'd130;
    bus.mant_in   = 48'h6000_0000_0000;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
    check("ovl.valid_dropped", 64'(bus.out_valid), 64'd0);
    check("ovl.idle_not_taken", 64'(bus.in_ready), 64'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    check("ovl.captured", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clock);
      lat++;
      #1;
    end
    check("ovl.second_latency", 64'(lat), 64'(lat_b));
    check("ovl.second_result", 64'(bus.result), 64'(r_b));
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1 bus.out_ready = 1'b0;
    $display("op overlap second res=%h lat=%0d", r_b, lat);

    // Reset during a long normalization discards the operation.
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.sign_in  = 1'b0;
    bus.exp_in   = 10'd200;
    bus.mant_in  = 48'h0000_0000_0001;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid.busy", 64'(bus.in_ready), 64'd0);
    #1 reset = 1'b1;
    #1;
    check("mid.rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid.rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    stale = 0;
    repeat (60) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) stale++;
    end
    check("mid.no_stale", 64'(stale), 64'd0);
    $display("op reset_mid_norm stale_cycles=%0d", stale);
    do_op("post_rst", vt[4].s, vt[4].ex, vt[4].mt, vt[4].res, vt[4].ov, vt[4].un, vt[4].lat, 0);

    for (int n = 0; n < 300; n++) begin
      logic        s;
      logic [9:0]  ex;
      logic [47:0] mt;
      logic [31:0] r;
      logic        ov, un;
      int          lr;
      int          sh;
      s  = 1'(($urandom));
      ex = 10'($urandom_range(0, 508) - 127);
      mt = {16'($urandom), $urandom};
      sh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(0, 47);
      mt = mt >> sh;
      if ($urandom_range(0, 19) == 0) mt = '0;
      ref_model(s, ex, mt, r, ov, un, lr);
      do_op($sformatf("rnd%0d", n), s, ex, mt, r, ov, un, lr, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
